// File: rtl/regfile_sequencer.sv
// Multi-cycle instruction sequencer driving the 4-register / accumulator file.
// Each accepted instruction walks READ -> EXEC -> WB and produces exactly one
// done pulse plus at most one write strobe, visible in the cycle after WB.
module regfile_sequencer #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [11:0]       instr,
    output logic [ADDR_W-1:0] rf_read_addr1,
    output logic [ADDR_W-1:0] rf_read_addr2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    input  logic [DATA_W-1:0] rf_acc_out,
    output logic              rf_write_enable,
    output logic [ADDR_W-1:0] rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_acc_write_enable,
    output logic [DATA_W-1:0] rf_acc_in,
    output logic              done,
    output logic              carry_flag,
    output logic              zero_flag,
    output logic              illegal
);

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OP_W-1:0] OP_LDI  = 4'h1;
    localparam logic [OP_W-1:0] OP_MOV  = 4'h2;
    localparam logic [OP_W-1:0] OP_ADD  = 4'h3;
    localparam logic [OP_W-1:0] OP_SUB  = 4'h4;
    localparam logic [OP_W-1:0] OP_AND  = 4'h5;
    localparam logic [OP_W-1:0] OP_OR   = 4'h6;
    localparam logic [OP_W-1:0] OP_XOR  = 4'h7;
    localparam logic [OP_W-1:0] OP_STA  = 4'h8;
    localparam logic [OP_W-1:0] OP_LDA  = 4'h9;
    localparam logic [OP_W-1:0] OP_ADDI = 4'hA;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic accept;

    // Latched instruction fields
    logic [OP_W-1:0]   opcode_q;
    logic [DATA_W-1:0] imm_q;

    // Operands captured in READ
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] op_acc;

    // Combinational execute results
    logic              x_we;
    logic [DATA_W-1:0] x_wdata;
    logic              x_acc_we;
    logic [DATA_W-1:0] x_acc_data;
    logic              x_carry_upd;
    logic              x_carry;
    logic              x_illegal;
    logic [DATA_W:0]   sum_rr;
    logic [DATA_W:0]   diff_rr;
    logic [DATA_W:0]   sum_ai;

    // Results held from EXEC for write-back
    logic              h_we;
    logic [DATA_W-1:0] h_wdata;
    logic              h_acc_we;
    logic [DATA_W-1:0] h_acc_data;
    logic              h_carry_upd;
    logic              h_carry;
    logic              h_illegal;

    // Ready only in IDLE, and never while reset is held
    assign instr_ready = (state == IDLE) && !reset;
    assign accept      = instr_valid && instr_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: fixed four-cycle walk per instruction
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = READ;
            READ:    state_next = EXEC;
            EXEC:    state_next = WB;
            WB:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Execute: decode opcode and compute result, strobes and carry
    always_comb begin
        sum_rr      = {1'b0, op_a} + {1'b0, op_b};
        diff_rr     = {1'b0, op_a} - {1'b0, op_b};
        sum_ai      = {1'b0, op_acc} + {1'b0, imm_q};
        x_we        = 1'b0;
        x_wdata     = '0;
        x_acc_we    = 1'b0;
        x_acc_data  = '0;
        x_carry_upd = 1'b0;
        x_carry     = 1'b0;
        x_illegal   = 1'b0;
        case (opcode_q)
            OP_NOP: ;
            OP_LDI: begin
                x_we    = 1'b1;
                x_wdata = imm_q;
            end
            OP_MOV: begin
                x_we    = 1'b1;
                x_wdata = op_b;
            end
            OP_ADD: begin
                x_acc_we    = 1'b1;
                x_acc_data  = sum_rr[DATA_W-1:0];
                x_carry_upd = 1'b1;
                x_carry     = sum_rr[DATA_W];
            end
            OP_SUB: begin
                x_acc_we    = 1'b1;
                x_acc_data  = diff_rr[DATA_W-1:0];
                x_carry_upd = 1'b1;
                x_carry     = diff_rr[DATA_W];
            end
            OP_AND: begin
                x_acc_we   = 1'b1;
                x_acc_data = op_a & op_b;
            end
            OP_OR: begin
                x_acc_we   = 1'b1;
                x_acc_data = op_a | op_b;
            end
            OP_XOR: begin
                x_acc_we   = 1'b1;
                x_acc_data = op_a ^ op_b;
            end
            OP_STA: begin
                x_we    = 1'b1;
                x_wdata = op_acc;
            end
            OP_LDA: begin
                x_acc_we   = 1'b1;
                x_acc_data = op_b;
            end
            OP_ADDI: begin
                x_acc_we    = 1'b1;
                x_acc_data  = sum_ai[DATA_W-1:0];
                x_carry_upd = 1'b1;
                x_carry     = sum_ai[DATA_W];
            end
            default: x_illegal = 1'b1;
        endcase
    end

    // Datapath: latch, operand capture, hold, and registered write-back
    always_ff @(posedge clk) begin
        if (reset) begin
            opcode_q            <= '0;
            imm_q               <= '0;
            rf_read_addr1       <= '0;
            rf_read_addr2       <= '0;
            op_a                <= '0;
            op_b                <= '0;
            op_acc              <= '0;
            h_we                <= 1'b0;
            h_wdata             <= '0;
            h_acc_we            <= 1'b0;
            h_acc_data          <= '0;
            h_carry_upd         <= 1'b0;
            h_carry             <= 1'b0;
            h_illegal           <= 1'b0;
            rf_write_enable     <= 1'b0;
            rf_write_addr       <= '0;
            rf_write_data       <= '0;
            rf_acc_write_enable <= 1'b0;
            rf_acc_in           <= '0;
            done                <= 1'b0;
            illegal             <= 1'b0;
            carry_flag          <= 1'b0;
            zero_flag           <= 1'b0;
        end else begin
            rf_write_enable     <= 1'b0;
            rf_acc_write_enable <= 1'b0;
            done                <= 1'b0;
            illegal             <= 1'b0;

            if (accept) begin
                opcode_q      <= instr[11:8];
                rf_read_addr1 <= ADDR_W'(instr[7:6]);
                rf_read_addr2 <= ADDR_W'(instr[5:4]);
                imm_q         <= DATA_W'(instr[3:0]);
            end

            if (state == READ) begin
                op_a   <= rf_read_data1;
                op_b   <= rf_read_data2;
                op_acc <= rf_acc_out;
            end

            if (state == EXEC) begin
                h_we        <= x_we;
                h_wdata     <= x_wdata;
                h_acc_we    <= x_acc_we;
                h_acc_data  <= x_acc_data;
                h_carry_upd <= x_carry_upd;
                h_carry     <= x_carry;
                h_illegal   <= x_illegal;
            end

            if (state == WB) begin
                done                <= 1'b1;
                illegal             <= h_illegal;
                rf_write_enable     <= h_we;
                rf_acc_write_enable <= h_acc_we;
                if (h_we) begin
                    rf_write_addr <= rf_read_addr1;
                    rf_write_data <= h_wdata;
                end
                if (h_acc_we) begin
                    rf_acc_in <= h_acc_data;
                    zero_flag <= (h_acc_data == '0);
                end
                if (h_carry_upd) begin
                    carry_flag <= h_carry;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: a behavioural register file, an architectural
// reference model feeding an expectation queue, and a monitor that checks
// every write-back against it.
module tb_regfile_sequencer;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned ADDR_W = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              instr_valid = 1'b0;
    logic              instr_ready;
    logic [11:0]       instr = '0;
    logic [ADDR_W-1:0] rf_read_addr1;
    logic [ADDR_W-1:0] rf_read_addr2;
    logic [DATA_W-1:0] rf_read_data1;
    logic [DATA_W-1:0] rf_read_data2;
    logic [DATA_W-1:0] rf_acc_out;
    logic              rf_write_enable;
    logic [ADDR_W-1:0] rf_write_addr;
    logic [DATA_W-1:0] rf_write_data;
    logic              rf_acc_write_enable;
    logic [DATA_W-1:0] rf_acc_in;
    logic              done;
    logic              carry_flag;
    logic              zero_flag;
    logic              illegal;

    regfile_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .rf_acc_out(rf_acc_out),
        .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data),
        .rf_acc_write_enable(rf_acc_write_enable), .rf_acc_in(rf_acc_in),
        .done(done), .carry_flag(carry_flag), .zero_flag(zero_flag),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy = 0;
    logic env_init = 1'b0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Behavioural register file seen by the DUT
    logic [3:0] env_regs [4];
    logic [3:0] env_acc;
    assign rf_read_data1 = env_regs[rf_read_addr1];
    assign rf_read_data2 = env_regs[rf_read_addr2];
    assign rf_acc_out    = env_acc;

    always @(posedge clk) begin
        if (!env_init) begin
            for (int i = 0; i < 4; i++) env_regs[i] <= '0;
            env_acc <= '0;
        end else begin
            if (rf_write_enable) env_regs[rf_write_addr] <= rf_write_data;
            if (rf_acc_write_enable) env_acc <= rf_acc_in;
        end
    end

    // Expected write-back of one instruction, plus model state before it
    typedef struct {
        logic       we;
        logic [1:0] waddr;
        logic [3:0] wdata;
        logic       acc_we;
        logic [3:0] acc_data;
        logic       carry;
        logic       zero;
        logic       ill;
        int         cyc;
        logic [3:0] s_regs [4];
        logic [3:0] s_acc;
    } exp_t;

    exp_t exp_q[$];

    int   mregs [4];
    int   macc;
    logic mcarry;
    logic mzero;

    // Reference model: architectural effect of each accepted instruction
    always @(posedge clk) begin
        exp_t e;
        int op, rd, rs, imm, a, b, res;
        bit acc_wr;
        cyc = cyc + 1;
        if (!env_init) begin
            for (int i = 0; i < 4; i++) mregs[i] = 0;
            macc = 0;
        end
        if (reset) begin
            if (exp_q.size() > 0) begin
                for (int i = 0; i < 4; i++) mregs[i] = int'(exp_q[0].s_regs[i]);
                macc = int'(exp_q[0].s_acc);
            end
            exp_q.delete();
            mcarry = 1'b0;
            mzero  = 1'b0;
            busy   = 0;
        end else if (instr_valid && busy == 0) begin
            op  = int'(instr[11:8]);
            rd  = int'(instr[7:6]);
            rs  = int'(instr[5:4]);
            imm = int'(instr[3:0]);
            a   = mregs[rd];
            b   = mregs[rs];
            for (int i = 0; i < 4; i++) e.s_regs[i] = 4'(mregs[i]);
            e.s_acc  = 4'(macc);
            e.we     = 1'b0;
            e.waddr  = 2'(rd);
            e.wdata  = '0;
            e.acc_we = 1'b0;
            e.ill    = 1'b0;
            acc_wr   = 1'b0;
            res      = 0;
            case (op)
                0: ;
                1: begin e.we = 1'b1; res = imm; end
                2: begin e.we = 1'b1; res = b; end
                3: begin acc_wr = 1'b1; res = (a + b) % 16; mcarry = (a + b) >= 16; end
                4: begin acc_wr = 1'b1; res = (a - b + 16) % 16; mcarry = (a < b); end
                5: begin acc_wr = 1'b1; res = a & b; end
                6: begin acc_wr = 1'b1; res = a | b; end
                7: begin acc_wr = 1'b1; res = a ^ b; end
                8: begin e.we = 1'b1; res = macc; end
                9: begin acc_wr = 1'b1; res = b; end
                10: begin acc_wr = 1'b1; res = (macc + imm) % 16; mcarry = (macc + imm) >= 16; end
                default: e.ill = 1'b1;
            endcase
            if (e.we) begin
                mregs[rd] = res;
                e.wdata = 4'(res);
            end
            if (acc_wr) begin
                macc = res;
                mzero = (res == 0);
                e.acc_we = 1'b1;
                e.acc_data = 4'(res);
            end
            e.carry = mcarry;
            e.zero  = mzero;
            e.cyc   = cyc;
            exp_q.push_back(e);
            busy = 3;
        end else if (busy > 0) begin
            busy = busy - 1;
        end
    end

    // Monitor: handshake, write-back contents, and spurious strobes
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        chk("instr_ready", int'(instr_ready), int'(busy == 0 && !reset));
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("latency", cyc - e.cyc, 3);
                chk("write_enable", int'(rf_write_enable), int'(e.we));
                if (e.we) begin
                    chk("write_addr", int'(rf_write_addr), int'(e.waddr));
                    chk("write_data", int'(rf_write_data), int'(e.wdata));
                end
                chk("acc_write_enable", int'(rf_acc_write_enable), int'(e.acc_we));
                if (e.acc_we) chk("acc_in", int'(rf_acc_in), int'(e.acc_data));
                chk("carry_flag", int'(carry_flag), int'(e.carry));
                chk("zero_flag", int'(zero_flag), int'(e.zero));
                chk("illegal", int'(illegal), int'(e.ill));
            end
        end else begin
            chk("no_strobe_without_done",
                int'({rf_write_enable, rf_acc_write_enable, illegal}), 0);
            if (exp_q.size() > 0 && (cyc - exp_q[0].cyc) > 6) begin
                chk("writeback_timeout", 0, 1);
                void'(exp_q.pop_front());
            end
        end
    end

    function automatic logic [11:0] enc(input int op, input int rd, input int rs, input int imm);
        return {4'(op), 2'(rd), 2'(rs), 4'(imm)};
    endfunction

    time t_acc;

    // Present an instruction until accepted; keep=1 leaves valid high afterwards
    task automatic issue(input logic [11:0] ins, input bit keep);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        instr_valid = 1'b1;
        instr = ins;
        for (int k = 0; k < 20 && !ok; k++) begin
            #1;
            if (instr_ready) begin
                @(posedge clk);
                t_acc = $time;
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        if (!keep) begin
            @(negedge clk);
            instr_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 12 && !ok; k++) begin
            @(negedge clk);
            #1;
            if (done) ok = 1'b1;
        end
        if (!ok) chk("done_timeout", 0, 1);
    endtask

    function automatic int all_outputs();
        return int'({rf_write_enable, rf_acc_write_enable, done, illegal,
                     carry_flag, zero_flag, rf_read_addr1, rf_read_addr2,
                     rf_write_addr, rf_write_data, rf_acc_in});
    endfunction

    initial begin
        time t0;
        // Reset state
        @(negedge clk);
        env_init = 1'b1;
        #1;
        chk("reset_outputs", all_outputs(), 0);
        chk("reset_ready", int'(instr_ready), 0);
        @(negedge clk);
        reset = 1'b0;

        // LDI R1,#9
        issue(12'h149, 1'b0);
        wait_done();
        chk("ldi_we", int'(rf_write_enable), 1);
        chk("ldi_addr", int'(rf_write_addr), 1);
        chk("ldi_data", int'(rf_write_data), 9);

        // LDI R0,#7; LDI R1,#12; ADD R0,R1
        issue(enc(1, 0, 0, 7), 1'b0);
        issue(enc(1, 1, 0, 12), 1'b0);
        issue(enc(3, 0, 1, 0), 1'b0);
        wait_done();
        chk("add_acc", int'(rf_acc_in), 3);
        chk("add_acc_we", int'(rf_acc_write_enable), 1);
        chk("add_we", int'(rf_write_enable), 0);
        chk("add_carry", int'(carry_flag), 1);
        chk("add_zero", int'(zero_flag), 0);

        // SUB to zero, then borrow
        issue(enc(1, 2, 0, 5), 1'b0);
        issue(enc(1, 3, 0, 5), 1'b0);
        issue(enc(4, 2, 3, 0), 1'b0);
        wait_done();
        chk("sub0_acc", int'(rf_acc_in), 0);
        chk("sub0_zero", int'(zero_flag), 1);
        chk("sub0_carry", int'(carry_flag), 0);
        issue(enc(1, 3, 0, 3), 1'b0);
        issue(enc(4, 3, 2, 0), 1'b0);
        wait_done();
        chk("sub_borrow_acc", int'(rf_acc_in), 14);
        chk("sub_borrow_carry", int'(carry_flag), 1);

        // acc=15 via LDA, ADDI wraps, STA stores without touching flags
        issue(enc(1, 0, 0, 15), 1'b0);
        issue(enc(9, 0, 0, 0), 1'b0);
        issue(enc(10, 0, 0, 1), 1'b0);
        wait_done();
        chk("addi_acc", int'(rf_acc_in), 0);
        chk("addi_carry", int'(carry_flag), 1);
        chk("addi_zero", int'(zero_flag), 1);
        issue(enc(8, 3, 0, 0), 1'b0);
        wait_done();
        chk("sta_addr", int'(rf_write_addr), 3);
        chk("sta_data", int'(rf_write_data), 0);
        chk("sta_flags", int'({carry_flag, zero_flag}), 3);

        // Illegal opcode with valid held high, then back-to-back accept
        issue(enc(12, 1, 2, 3), 1'b1);
        t0 = t_acc;
        issue(enc(0, 0, 0, 0), 1'b0);
        chk("b2b_spacing", int'(t_acc - t0), 40);
        wait_done();

        // Reset during EXEC of an ADD
        issue(enc(3, 0, 1, 0), 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_outputs", all_outputs(), 0);
        chk("abort_ready", int'(instr_ready), 1);
        repeat (6) @(negedge clk);

        // Random traffic with occasional reset
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            instr_valid = ($urandom_range(0, 2) != 0);
            instr = 12'($urandom);
            reset = ($urandom_range(0, 59) == 0);
        end
        @(negedge clk);
        instr_valid = 1'b0;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
